// File: rtl/fifo_stream_drain_if.sv
// fifo_stream_drain_if: FIFO read port plus framed valid/ready stream between the drain and its neighbours
interface fifo_stream_drain_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_read;
    logic [WIDTH-1:0] fifo_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_read, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_read, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pops a registered-output FIFO into a burst-framed valid/ready stream
module fifo_stream_drain #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_enable,
    fifo_stream_drain_if.master        bus,
    output logic [15:0]                o_word_count,
    output logic                       o_idle
);
    logic [WIDTH-1:0] r_mem [3];
    logic [1:0]       r_occ;
    logic [1:0]       r_head;
    logic [1:0]       r_tail;
    logic             r_infl;
    logic [15:0]      r_bcnt;
    logic [15:0]      r_wc;
    logic [2:0]       w_used;
    logic             w_pop;
    logic             w_wrap;

    function automatic logic [1:0] inc(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction

    // reads are gated by buffer space reserved for the in-flight word, never by m_ready
    assign w_used        = {1'b0, r_occ} + {2'b0, r_infl};
    assign bus.fifo_read = ~rst & i_enable & ~bus.fifo_empty & (w_used < 3'd3);
    assign bus.m_valid   = r_occ != 2'd0;
    assign bus.m_data    = r_mem[r_head];
    assign w_wrap        = r_bcnt == 16'(BURST_LEN - 1);
    assign bus.m_last    = bus.m_valid & w_wrap;
    assign w_pop         = bus.m_valid & bus.m_ready;
    assign o_idle        = (r_occ == 2'd0) & ~r_infl;
    assign o_word_count  = r_wc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem  <= '{default: '0};
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_infl <= 1'b0;
            r_bcnt <= '0;
            r_wc   <= '0;
        end else begin
            r_infl <= bus.fifo_read;
            if (r_infl) begin
                r_mem[r_tail] <= bus.fifo_data;
                r_tail        <= inc(r_tail);
            end
            if (w_pop) begin
                r_head <= inc(r_head);
                r_bcnt <= w_wrap ? 16'd0 : r_bcnt + 16'd1;
                r_wc   <= r_wc + 16'd1;
            end
            r_occ <= r_occ + {1'b0, r_infl} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: queue-backed FIFO model feeding the drain, scoreboard monitor on the stream side
module tb_fifo_stream_drain;
    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] wc;
    logic        idle;
    logic [7:0]  fq[$];
    exp_t        exq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rd = 0;
    int          n_under = 0;
    int          cyc = 0;
    int          t_rd = -1;
    int          t_v = -1;
    int          t_last = -1;
    logic        held = 1'b0;
    logic [7:0]  held_d = '0;
    int          base;

    fifo_stream_drain_if #(.WIDTH(8)) bus();

    fifo_stream_drain #(.WIDTH(8), .BURST_LEN(16)) dut (
        .clk(clk),
        .rst(rst),
        .i_enable(enable),
        .bus(bus),
        .o_word_count(wc),
        .o_idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l);
        exq.push_back('{d: d, l: l});
    endtask

    task automatic wait_wc(input int target);
        int n = 0;
        while (wc != 16'(target) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_word_count", int'(wc), target);
    endtask

    // FIFO model: registered read data and registered empty flag
    always @(posedge clk) begin
        if (bus.fifo_read) begin
            n_rd++;
            if (fq.size() == 0) n_under++;
            else bus.fifo_data <= fq.pop_front();
        end
        bus.fifo_empty <= fq.size() == 0;
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.fifo_read && t_rd < 0) t_rd = cyc;
        if (bus.m_valid && t_v < 0) t_v = cyc;
        if (held) begin
            chk("hold_valid", int'(bus.m_valid), 1);
            chk("hold_data", int'(bus.m_data), int'(held_d));
        end
        held = bus.m_valid & ~bus.m_ready & ~rst;
        held_d = bus.m_data;
        if (bus.m_valid && bus.m_ready && !rst) begin
            t_last = cyc;
            if (exq.size() == 0) begin
                chk("unexpected_word", int'(bus.m_data), -1);
            end else begin
                e = exq.pop_front();
                chk("sb_data", int'(bus.m_data), int'(e.d));
                chk("sb_last", int'(bus.m_last), int'(e.l));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        bus.m_ready    = 1'b1;
        for (int i = 0; i < 32; i++) begin
            fq.push_back(8'(i));
            push_exp(8'(i), i % 16 == 15);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fifo_empty_low", int'(bus.fifo_empty), 0);
        chk("rst_fifo_read", int'(bus.fifo_read), 0);
        chk("rst_m_valid", int'(bus.m_valid), 0);
        chk("rst_m_last", int'(bus.m_last), 0);
        chk("rst_m_data", int'(bus.m_data), 0);
        chk("rst_idle", int'(idle), 1);
        chk("rst_word_count", int'(wc), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_m_valid", int'(bus.m_valid), 0);
        chk("rel_idle", int'(idle), 1);
        chk("rel_word_count", int'(wc), 0);
        chk("rel_fifo_read", int'(bus.fifo_read), 1);
        wait_wc(32);
        chk("first_word_latency", t_v - t_rd, 2);
        chk("stream_span", t_last - t_v, 31);
        chk("stream_drained", exq.size(), 0);

        @(posedge clk); #1 bus.m_ready = 1'b0;
        base = n_rd;
        for (int i = 0; i < 16; i++) begin
            fq.push_back(8'(8'h40 + i));
            push_exp(8'(8'h40 + i), i == 15);
        end
        repeat (12) @(negedge clk);
        chk("bp_reads", n_rd - base, 3);
        chk("bp_m_valid", int'(bus.m_valid), 1);
        chk("bp_m_data", int'(bus.m_data), 'h40);
        chk("bp_fifo_read_low", int'(bus.fifo_read), 0);
        @(posedge clk); #1 bus.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_same_cycle_read", int'(bus.fifo_read), 0);
        @(negedge clk);
        chk("bp_read_resumes", int'(bus.fifo_read), 1);
        wait_wc(48);
        chk("bp_total_reads", n_rd - base, 16);
        chk("bp_drained", exq.size(), 0);

        @(posedge clk); #1 enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            fq.push_back(8'(8'h60 + i));
            push_exp(8'(8'h60 + i), i == 15);
        end
        repeat (4) @(negedge clk);
        chk("en_low_no_read", int'(bus.fifo_read), 0);
        chk("en_low_idle", int'(idle), 1);
        @(posedge clk); #1 enable = 1'b1;
        base = n_rd;
        repeat (5) @(posedge clk);
        #1 enable = 1'b0;
        repeat (6) @(negedge clk);
        chk("en_reads", n_rd - base, 5);
        chk("en_word_count", int'(wc), 53);
        chk("en_idle", int'(idle), 1);
        chk("en_m_valid", int'(bus.m_valid), 0);
        chk("en_bcnt", int'(dut.r_bcnt), 5);
        @(posedge clk); #1 enable = 1'b1;
        wait_wc(68);
        chk("en_total_reads", n_rd - base, 20);
        chk("en_drained", exq.size(), 0);

        base = n_rd;
        repeat (8) @(negedge clk);
        chk("empty_no_reads", n_rd - base, 0);
        chk("empty_fifo_read", int'(bus.fifo_read), 0);
        chk("empty_idle", int'(idle), 1);

        @(posedge clk); #1 bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) fq.push_back(8'(8'h80 + i));
        begin
            int n = 0;
            while (!(dut.r_occ == 2'd2 && dut.r_infl) && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("mid_rst_state_reached", int'(dut.r_occ == 2'd2 && dut.r_infl), 1);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_valid", int'(bus.m_valid), 0);
        chk("mid_rst_word_count", int'(wc), 0);
        chk("mid_rst_idle", int'(idle), 1);
        exq.delete();
        for (int i = 0; i < 16; i++) begin
            if (i >= 7) fq.push_back(8'(8'h83 + i));
            push_exp(8'(8'h83 + i), i == 15);
        end
        wait_wc(16);
        chk("mid_rst_drained", exq.size(), 0);
        chk("fifo_underflow", n_under, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
